// File: rtl/button_debounce.sv
// Synchronises one raw active-low push button, filters contact bounce and
// emits a single-cycle pulse each time a press is accepted.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic clk,
   input  logic reset,
   input  logic rawN,
   output logic pressed,
   output logic pressEv
);

   localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          ev_q, ev_d;
   logic [TW-1:0] timer_q, timer_d;

   // Two-flop synchroniser. The pin is inverted ahead of the chain so a
   // cleared flop already means "released", and no phantom difference is
   // seen while the chain refills after reset.
   // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would collapse the two synchroniser stages into one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= ~rawN;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count while the synced level disagrees with the accepted one,
   // flip after DEBOUNCE_CYCLES disagreeing cycles, pulse on a new press.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is never inferred.
   always_comb begin
      level_d = level_q;
      timer_d = '0;
      ev_d    = 1'b0;
      if (sync2_q != level_q) begin
         if (timer_q == TIMER_LAST) begin
            level_d = sync2_q;
            ev_d    = sync2_q;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
   end

   // Accepted level, debounce timer and the registered press pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= 1'b0;
         timer_q <= '0;
         ev_q    <= 1'b0;
      end else begin
         level_q <= level_d;
         timer_q <= timer_d;
         ev_q    <= ev_d;
      end
   end

   assign pressed = level_q;
   assign pressEv = ev_q;

endmodule

// File: rtl/decode_addr_stepper.sv
// Drives the 4-bit select of the 4-to-16 LED decoder. Up/down buttons step
// the address by hand; the run button toggles an auto-increment mode that
// advances the address once every STEP_CYCLES clocks.
module decode_addr_stepper #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int STEP_CYCLES     = 6000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btnUp,
   input  logic btnDown,
   input  logic btnRun,
   output logic a3,
   output logic a2,
   output logic a1,
   output logic a0,
   output logic running,
   output logic wrap
);

   localparam logic MANUAL = 1'b0;
   localparam logic RUN    = 1'b1;

   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

   logic          up_ev, down_ev, run_ev;
   logic [2:0]    unused_pressed;
   logic          state_q, state_d;
   logic [3:0]    addr_q, addr_d;
   logic [SW-1:0] step_q, step_d;
   logic          wrap_q, wrap_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk     (clk),
      .reset   (reset),
      .rawN    (btnUp),
      .pressed (unused_pressed[0]),
      .pressEv (up_ev)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk     (clk),
      .reset   (reset),
      .rawN    (btnDown),
      .pressed (unused_pressed[1]),
      .pressEv (down_ev)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
      .clk     (clk),
      .reset   (reset),
      .rawN    (btnRun),
      .pressed (unused_pressed[2]),
      .pressEv (run_ev)
   );

   // Mode FSM and address stepping; the run button outranks up/down, and the
   // step timer only counts in RUN so it is zero whenever RUN is entered.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      step_d  = '0;
      wrap_d  = 1'b0;
      if (state_q == MANUAL) begin
         if (run_ev) begin
            state_d = RUN;
         end else if (up_ev && !down_ev) begin
            addr_d = addr_q + 4'd1;
            wrap_d = (addr_q == 4'hF);
         end else if (down_ev && !up_ev) begin
            addr_d = addr_q - 4'd1;
            wrap_d = (addr_q == 4'h0);
         end
      end else begin
         if (run_ev) begin
            state_d = MANUAL;
         end else if (step_q == STEP_LAST) begin
            addr_d = addr_q + 4'd1;
            wrap_d = (addr_q == 4'hF);
         end else begin
            step_d = step_q + SW'(1);
         end
      end
   end

   // Mode, address, step timer and wrap pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MANUAL;
         addr_q  <= 4'h0;
         step_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   assign {a3, a2, a1, a0} = addr_q;
   assign running          = (state_q == RUN);
   assign wrap             = wrap_q;

endmodule

// File: tb/tb_decode_addr_stepper.sv
// Scoreboard bench for decode_addr_stepper: stimulus tasks drive button
// actions and queue the outputs the address-stepping rules predict; a
// monitor pops an entry whenever the outputs change or wrap pulses.
module tb_decode_addr_stepper;

   localparam int DEB  = 4;
   localparam int STEP = 8;
   localparam int LAT  = 2 + DEB + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btnUp = 1'b1, btnDown = 1'b1, btnRun = 1'b1;
   logic a3, a2, a1, a0, running, wrap;
   logic [3:0] a_bus;

   always #5 clk = ~clk;

   decode_addr_stepper #(.DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(STEP)) dut (
      .clk     (clk),
      .reset   (reset),
      .btnUp   (btnUp),
      .btnDown (btnDown),
      .btnRun  (btnRun),
      .a3      (a3),
      .a2      (a2),
      .a1      (a1),
      .a0      (a0),
      .running (running),
      .wrap    (wrap)
   );

   assign a_bus = {a3, a2, a1, a0};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] a;
      bit         run;
      bit         wrp;
      int         at;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   int   m_addr = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input int a, input bit r, input bit w, input int at);
      exp_t e;
      e.a   = a[3:0];
      e.run = r;
      e.wrp = w;
      e.at  = at;
      sb.push_back(e);
   endfunction

   // Monitor: samples just after each falling edge.
   logic [4:0] prev_s, cur_s;
   exp_t       got;
   initial begin
      prev_s = '0;
      forever begin
         @(negedge clk);
         #1;
         cur_s = {a_bus, running};
         if (mon_en) begin
            if (sb.size() > 0 && sb[0].at < cyc) begin
               checks++;
               errors++;
               $display("FAIL missed_output: expected a=%h due cycle %0d, nothing by cycle %0d",
                        sb[0].a, sb[0].at, cyc);
               void'(sb.pop_front());
            end
            if (cur_s != prev_s || wrap) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: a=%h running=%b wrap=%b at cycle %0d",
                           a_bus, running, wrap, cyc);
               end else begin
                  got = sb.pop_front();
                  check("addr", int'(a_bus), int'(got.a));
                  check("running", int'(running), int'(got.run));
                  check("wrap", int'(wrap), int'(got.wrp));
                  check("change_cycle", cyc, got.at);
               end
            end
         end
         prev_s = cur_s;
      end
   end

   // Clean press of up and/or down held for 'hold' cycles, then released.
   task automatic press_manual(input bit up, input bit dn, input int hold);
      int t;
      @(negedge clk);
      t = cyc;
      if (up && !dn) begin
         m_addr = (m_addr + 1) % 16;
         push(m_addr, 1'b0, m_addr == 0, t + LAT);
      end else if (dn && !up) begin
         m_addr = (m_addr + 15) % 16;
         push(m_addr, 1'b0, m_addr == 15, t + LAT);
      end
      btnUp   = !up;
      btnDown = !dn;
      repeat (hold) @(negedge clk);
      btnUp   = 1'b1;
      btnDown = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // Up button chattering with 2-cycle pulses: never stable long enough.
   task automatic bounce_up();
      @(negedge clk);
      repeat (6) begin
         btnUp = 1'b0;
         repeat (2) @(negedge clk);
         btnUp = 1'b1;
         repeat (2) @(negedge clk);
      end
      repeat (10) @(negedge clk);
   endtask

   // Enter RUN, stay run_len cycles between the two run presses, leave RUN.
   task automatic run_session(input bit with_up, input bit up_during, input int run_len);
      int c0, c1, t;
      @(negedge clk);
      c0 = cyc;
      c1 = c0 + run_len;
      push(m_addr, 1'b1, 1'b0, c0 + LAT);
      t = c0 + LAT + STEP;
      while (t < c1 + LAT) begin
         m_addr = (m_addr + 1) % 16;
         push(m_addr, 1'b1, m_addr == 0, t);
         t += STEP;
      end
      push(m_addr, 1'b0, 1'b0, c1 + LAT);
      btnRun = 1'b0;
      if (with_up) btnUp = 1'b0;
      repeat (10) @(negedge clk);
      btnRun = 1'b1;
      btnUp  = 1'b1;
      if (up_during) begin
         repeat (2) @(negedge clk);
         btnUp = 1'b0;
         repeat (10) @(negedge clk);
         btnUp = 1'b1;
      end
      while (cyc < c1) @(negedge clk);
      btnRun = 1'b0;
      repeat (10) @(negedge clk);
      btnRun = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int c0, t, r, budget;

      // Reset with buttons released.
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_addr", int'(a_bus), 0);
      check("reset_running", int'(running), 0);
      check("reset_wrap", int'(wrap), 0);
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (50) @(negedge clk);
      check("idle_addr", int'(a_bus), 0);

      // Clean up press, then bounce.
      press_manual(1'b1, 1'b0, 10);
      bounce_up();
      check("after_bounce_addr", int'(a_bus), 1);

      // Wrap downwards and upwards, then a full lap of 16 ups.
      press_manual(1'b0, 1'b1, 10);
      press_manual(1'b0, 1'b1, 10);
      press_manual(1'b1, 1'b0, 10);
      repeat (16) press_manual(1'b1, 1'b0, 10);
      check("after_lap_addr", int'(a_bus), 0);

      // Simultaneous up+down, then run together with up.
      press_manual(1'b1, 1'b1, 10);
      run_session(1'b1, 1'b0, 30);

      // RUN from E: E, F, 0 (wrap), 1; up pressed mid-run is ignored.
      while (m_addr != 14) press_manual(1'b0, 1'b1, 10);
      run_session(1'b0, 1'b1, 28);
      check("run_exit_addr", int'(a_bus), 1);

      // Randomised mix of actions.
      repeat (40) begin
         r = $urandom_range(0, 4);
         case (r)
            0: press_manual(1'b1, 1'b0, $urandom_range(8, 12));
            1: press_manual(1'b0, 1'b1, $urandom_range(8, 12));
            2: press_manual(1'b1, 1'b1, $urandom_range(8, 12));
            3: bounce_up();
            default: run_session(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
                                 $urandom_range(26, 60));
         endcase
      end

      // Reset in RUN while an up press is part-way through debounce.
      @(negedge clk);
      c0 = cyc;
      push(m_addr, 1'b1, 1'b0, c0 + LAT);
      btnRun = 1'b0;
      repeat (10) @(negedge clk);
      btnRun = 1'b1;
      @(negedge clk);
      btnUp = 1'b0;
      repeat (3) @(negedge clk);
      check("queue_before_reset", sb.size(), 0);
      mon_en = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_addr", int'(a_bus), 0);
      check("async_reset_running", int'(running), 0);
      check("async_reset_wrap", int'(wrap), 0);
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      t      = cyc;
      m_addr = 1;
      push(m_addr, 1'b0, 1'b0, t + LAT);
      mon_en = 1'b1;
      repeat (10) @(negedge clk);
      btnUp = 1'b1;
      repeat (12) @(negedge clk);

      // Drain the scoreboard with a bounded wait.
      budget = 100;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("scoreboard_empty", sb.size(), 0);
      check("final_addr", int'(a_bus), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
